// File: rtl/pipeline_control_unit_pkg.sv
// Shared state encodings and default parameters for the pipeline control unit.
package pipeline_control_unit_pkg;

   typedef enum logic [1:0] {
      PCU_RUN      = 2'd0,
      PCU_MEM_WAIT = 2'd1,
      PCU_ERROR    = 2'd2
   } pcu_state_e;

   localparam int PCU_MEM_TIMEOUT = 64;
   localparam int PCU_CNT_W       = 16;

endpackage

// File: rtl/pipeline_control_unit_sat_counter.sv
// Saturating up-counter: one-cycle update, clear wins over increment, holds at all-ones.
// No backpressure; the count simply stops at its maximum.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer: zero-latency freeze/flush/bubble controls, registered FSM and counters.
// A memory freeze dominates branches and hazards; SRAM waits hold the whole pipe until ready.
module pipeline_control_unit
   import pipeline_control_unit_pkg::*;
#(
   parameter int MEM_TIMEOUT = PCU_MEM_TIMEOUT,
   parameter int CNT_W       = PCU_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             has_hazard,
   input  logic             branch_taken,
   input  logic             mem_access,
   input  logic             mem_ready,
   input  logic             perf_clr,
   output logic             mem_start,
   output logic             freeze_pc,
   output logic             freeze_if_id,
   output logic             freeze_id_exe,
   output logic             freeze_exe_mem,
   output logic             bubble_mem_wb,
   output logic             flush_if_id,
   output logic             flush_id_exe,
   output logic             mem_error,
   output logic [CNT_W-1:0] hazard_stalls,
   output logic [CNT_W-1:0] mem_stalls,
   output logic [CNT_W-1:0] flushes
);

   localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

   pcu_state_e      state_q, state_d;
   logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
   logic            mem_error_q, mem_error_d;
   logic            mfrz, br_act, hz_act, mstall_inc;

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      mem_error_d = mem_error_q;
      mfrz        = 1'b0;
      mem_start   = 1'b0;
      case (state_q)
         PCU_RUN: begin
            if (mem_access) begin
               mfrz       = 1'b1;
               mem_start  = 1'b1;
               state_d    = PCU_MEM_WAIT;
               wait_cnt_d = '0;
            end
         end
         PCU_MEM_WAIT: begin
            // ready releases the freeze in the same cycle so MEM advances to WB
            if (mem_ready) begin
               state_d = PCU_RUN;
            end else begin
               mfrz = 1'b1;
               if (wait_cnt_q == WC_LAST) begin
                  state_d     = PCU_ERROR;
                  mem_error_d = 1'b1;
               end else begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end
         end
         PCU_ERROR: mfrz = 1'b1;
         default:   state_d = PCU_RUN;
      endcase
      if (rst) begin
         mfrz      = 1'b0;
         mem_start = 1'b0;
      end
   end

   assign br_act     = !rst && !mfrz && branch_taken;
   assign hz_act     = !rst && !mfrz && !branch_taken && has_hazard;
   assign mstall_inc = mfrz && (state_q != PCU_ERROR);

   assign freeze_pc      = mfrz | hz_act;
   assign freeze_if_id   = mfrz | hz_act;
   assign freeze_id_exe  = mfrz;
   assign freeze_exe_mem = mfrz;
   assign bubble_mem_wb  = mfrz;
   assign flush_if_id    = br_act;
   assign flush_id_exe   = br_act | hz_act;
   assign mem_error      = mem_error_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= PCU_RUN;
         wait_cnt_q  <= '0;
         mem_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_error_q <= mem_error_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_hazard_cnt (
      .clk(clk), .rst(rst), .clr(perf_clr), .inc(hz_act), .cnt(hazard_stalls)
   );

   sat_counter #(.CNT_W(CNT_W)) u_mem_cnt (
      .clk(clk), .rst(rst), .clr(perf_clr), .inc(mstall_inc), .cnt(mem_stalls)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk(clk), .rst(rst), .clr(perf_clr), .inc(br_act), .cnt(flushes)
   );

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: directed scenarios plus random traffic against a cycle model.
module tb_pipeline_control_unit;

   localparam int TMO   = 8;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst, has_hazard, branch_taken, mem_access, mem_ready, perf_clr;
   logic mem_start, freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem;
   logic bubble_mem_wb, flush_if_id, flush_id_exe, mem_error;
   logic [CW-1:0] hazard_stalls, mem_stalls, flushes;

   int checks = 0;
   int errors = 0;

   // reference model: where the memory instruction is, and how long it has waited
   int m_phase = 0;   // 0 = no access pending, 1 = waiting on SRAM, 2 = timed out
   int m_spent = 0;
   bit m_err   = 0;
   int m_hz = 0, m_ms = 0, m_fl = 0;

   pipeline_control_unit #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .has_hazard(has_hazard), .branch_taken(branch_taken),
      .mem_access(mem_access), .mem_ready(mem_ready), .perf_clr(perf_clr),
      .mem_start(mem_start), .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id),
      .freeze_id_exe(freeze_id_exe), .freeze_exe_mem(freeze_exe_mem),
      .bubble_mem_wb(bubble_mem_wb), .flush_if_id(flush_if_id), .flush_id_exe(flush_id_exe),
      .mem_error(mem_error), .hazard_stalls(hazard_stalls), .mem_stalls(mem_stalls),
      .flushes(flushes)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   // one clock: drive at negedge, compare just after, advance model at posedge
   task automatic step(input bit r, input bit hz, input bit br, input bit acc,
                       input bit rdy, input bit clr);
      bit frz, br_a, hz_a, st;
      @(negedge clk);
      rst = r; has_hazard = hz; branch_taken = br;
      mem_access = acc; mem_ready = rdy; perf_clr = clr;
      #1;
      frz  = !r && ((m_phase == 0 && acc) || (m_phase == 1 && !rdy) || m_phase == 2);
      st   = !r && m_phase == 0 && acc;
      br_a = !r && !frz && br;
      hz_a = !r && !frz && !br && hz;
      chk("mem_start",      mem_start,      st);
      chk("freeze_pc",      freeze_pc,      frz | hz_a);
      chk("freeze_if_id",   freeze_if_id,   frz | hz_a);
      chk("freeze_id_exe",  freeze_id_exe,  frz);
      chk("freeze_exe_mem", freeze_exe_mem, frz);
      chk("bubble_mem_wb",  bubble_mem_wb,  frz);
      chk("flush_if_id",    flush_if_id,    br_a);
      chk("flush_id_exe",   flush_id_exe,   br_a | hz_a);
      chk("mem_error",      mem_error,      r ? 0 : m_err);
      chk("hazard_stalls",  hazard_stalls,  r ? 0 : m_hz);
      chk("mem_stalls",     mem_stalls,     r ? 0 : m_ms);
      chk("flushes",        flushes,        r ? 0 : m_fl);
      @(posedge clk);
      if (r) begin
         m_phase = 0; m_spent = 0; m_err = 0; m_hz = 0; m_ms = 0; m_fl = 0;
      end else begin
         if (clr) begin
            m_hz = 0; m_ms = 0; m_fl = 0;
         end else begin
            if (hz_a) m_hz = sat_inc(m_hz);
            if (br_a) m_fl = sat_inc(m_fl);
            if (frz && m_phase != 2) m_ms = sat_inc(m_ms);
         end
         if (m_phase == 0 && acc) begin
            m_phase = 1; m_spent = 0;
         end else if (m_phase == 1) begin
            if (rdy) m_phase = 0;
            else begin
               m_spent++;
               if (m_spent == TMO) begin m_phase = 2; m_err = 1; end
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; has_hazard = 0; branch_taken = 0; mem_access = 0; mem_ready = 0; perf_clr = 0;

      // reset with active-looking inputs: everything must stay quiet
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 1, 1, 1, 0);

      // hazard only
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("hazard_only_cnt", hazard_stalls, 1);

      // branch and hazard together: branch wins
      step(0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("branch_hz_flushes", flushes, 1);
      chk("branch_hz_hazards", hazard_stalls, 1);
      step(0, 0, 0, 0, 0, 1);

      // single load, ready at cycle 3, branch held in cycles 1-3
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 1, 1, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("load_mem_stalls", mem_stalls, 3);
      chk("load_flushes", flushes, 1);

      // back-to-back loads with no idle cycle, fastest possible ready
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 1, 0);
      step(0, 1, 0, 1, 0, 0);
      step(0, 1, 0, 1, 1, 0);
      step(0, 0, 0, 0, 0, 0);

      // ready on the final allowed wait cycle beats the timeout
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < TMO - 1; i++) step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("late_ready_no_err", mem_error, 0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0));
      end

      // counter saturation and clear priority
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("hz_clear_wins", hazard_stalls, 0);

      // timeout into sticky error, then reset clears it
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < TMO + 5; i++) step(0, 0, 1, 1, 0, 0);
      chk("timeout_err", mem_error, 1);
      chk("timeout_mstalls", mem_stalls, TMO + 1);
      chk("timeout_freeze", freeze_pc, 1);
      step(1, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("post_rst_err", mem_error, 0);
      chk("post_rst_mstalls", mem_stalls, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
